// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: branch classes, carry-writing ALU ops,
// control FSM states and the sequential instruction stride.
package kgp_pkg;

    // Branch class encodings from decode; 9..15 behave as BR_NONE.
    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_B    = 4'd1;
    localparam logic [3:0] BR_L    = 4'd2;
    localparam logic [3:0] BR_R    = 4'd3;
    localparam logic [3:0] BR_LTZ  = 4'd4;
    localparam logic [3:0] BR_Z    = 4'd5;
    localparam logic [3:0] BR_NZ   = 4'd6;
    localparam logic [3:0] BR_CY   = 4'd7;
    localparam logic [3:0] BR_NCY  = 4'd8;

    // The only ALU ops that write the architectural carry flag.
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_COMP = 4'b0101;

    // Byte stride between sequential instructions.
    localparam int INSTR_B = 4;

    // Target source select produced by branch_cond.
    localparam logic TGT_IMM = 1'b0;   // br_target from decode
    localparam logic TGT_ALU = 1'b1;   // register target via alu_result

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch resolution: decides whether the current instruction redirects the pc
// and which target source to use. Purely combinational.
module branch_cond
    import kgp_pkg::*;
(
    input  logic [3:0] br_type,
    input  logic       f_zero,
    input  logic       f_sign,
    input  logic       carry_q,
    output logic       take,
    output logic       tgt_sel
);

    // Conditional branches on carry use the flag as it stood before this
    // instruction; ALU flags are from the current cycle.
    always_comb begin
        take    = 1'b0;
        tgt_sel = TGT_IMM;
        case (br_type)
            BR_B:    take = 1'b1;
            BR_L:    take = 1'b1;
            BR_R: begin
                take    = 1'b1;
                tgt_sel = TGT_ALU;
            end
            BR_LTZ:  take = f_sign;
            BR_Z:    take = f_zero;
            BR_NZ:   take = ~f_zero;
            BR_CY:   take = carry_q;
            BR_NCY:  take = ~carry_q;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_flag_unit.sv
// KGP-RISC pc sequencing, carry flag and RUN/HALT control.
module branch_flag_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INSTR_B  = kgp_pkg::INSTR_B
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            stall,
    input  logic [3:0]      alu_op,
    input  logic [31:0]     alu_result,
    input  logic            f_zero,
    input  logic            f_sign,
    input  logic            f_carry,
    input  logic [3:0]      br_type,
    input  logic [PC_W-1:0] br_target,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] link_addr,
    output logic            link_we,
    output logic            taken,
    output logic            carry_q,
    output logic            halted
);

    import kgp_pkg::*;

    localparam logic [PC_W-1:0] PC_INC = PC_W'(INSTR_B);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic            carry_d;
    state_t          state_q, state_d;

    logic            adv;
    logic            take;
    logic            tgt_sel;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] tgt;

    branch_cond u_cond (
        .br_type (br_type),
        .f_zero  (f_zero),
        .f_sign  (f_sign),
        .carry_q (carry_q),
        .take    (take),
        .tgt_sel (tgt_sel)
    );

    assign adv    = en & ~stall & (state_q == S_RUN);
    assign seq_pc = pc_q + PC_INC;          // wraps silently at 2^PC_W
    assign tgt    = (tgt_sel == TGT_ALU) ? PC_W'(alu_result) : br_target;

    // Next-state: everything holds unless an instruction advances in RUN;
    // a halt request suppresses any branch in the same instruction.
    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        carry_d = carry_q;
        state_d = state_q;
        if (adv) begin
            if ((alu_op == OP_ADD) || (alu_op == OP_COMP)) begin
                carry_d = f_carry;
            end
            if (halt_req) begin
                state_d = S_HALT;
                taken_d = 1'b0;
            end else begin
                pc_d    = take ? tgt : seq_pc;
                taken_d = take;
            end
        end
    end

    // State registers with synchronous reset that also discards any branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            carry_q <= 1'b0;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            carry_q <= carry_d;
            state_q <= state_d;
        end
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign halted    = (state_q == S_HALT);
    assign link_addr = seq_pc;
    assign link_we   = adv & ~halt_req & (br_type == BR_L);

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed-vector bench for branch_flag_unit with a queue-based scoreboard.
module tb_branch_flag_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] alu_result = 32'd0;
    logic        f_zero = 1'b0;
    logic        f_sign = 1'b0;
    logic        f_carry = 1'b0;
    logic [3:0]  br_type = 4'd0;
    logic [31:0] br_target = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        link_we;
    logic        taken;
    logic        carry_q;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        taken;
        logic        carry;
        logic        halted;
        logic        lwe;
        logic [31:0] laddr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_flag_unit #(
        .PC_W     (32),
        .RESET_PC (32'h0),
        .INSTR_B  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .stall      (stall),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .f_zero     (f_zero),
        .f_sign     (f_sign),
        .f_carry    (f_carry),
        .br_type    (br_type),
        .br_target  (br_target),
        .halt_req   (halt_req),
        .pc         (pc),
        .link_addr  (link_addr),
        .link_we    (link_we),
        .taken      (taken),
        .carry_q    (carry_q),
        .halted     (halted)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s.%s got=0x%08h expected=0x%08h", nm, fld, act, expv);
        end
    endtask

    // One cycle of stimulus: inputs applied at negedge, expectation queued.
    task automatic txn(input string nm, input logic r, input logic e, input logic s,
                       input logic [3:0] op, input logic fz, input logic fs, input logic fc,
                       input logic [3:0] bt, input logic [31:0] tg, input logic [31:0] res,
                       input logic h, input logic [31:0] x_pc, input logic x_tk,
                       input logic x_cy, input logic x_h, input logic x_lwe,
                       input logic [31:0] x_la);
        exp_t ex;
        @(negedge clk);
        rst = r; en = e; stall = s; alu_op = op; f_zero = fz; f_sign = fs; f_carry = fc;
        br_type = bt; br_target = tg; alu_result = res; halt_req = h;
        ex.name = nm; ex.pc = x_pc; ex.taken = x_tk; ex.carry = x_cy;
        ex.halted = x_h; ex.lwe = x_lwe; ex.laddr = x_la;
        exp_q.push_back(ex);
    endtask

    // Monitor: samples comb link outputs mid-cycle, registered state after the edge.
    initial begin
        exp_t ex;
        logic m_lwe;
        logic [31:0] m_la;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                ex    = exp_q[0];
                m_lwe = link_we;
                m_la  = link_addr;
                @(posedge clk);
                #1;
                chk(ex.name, "pc", pc, ex.pc);
                chk(ex.name, "taken", {31'd0, taken}, {31'd0, ex.taken});
                chk(ex.name, "carry_q", {31'd0, carry_q}, {31'd0, ex.carry});
                chk(ex.name, "halted", {31'd0, halted}, {31'd0, ex.halted});
                chk(ex.name, "link_we", {31'd0, m_lwe}, {31'd0, ex.lwe});
                if (ex.lwe) chk(ex.name, "link_addr", m_la, ex.laddr);
                $display("[TB] txn %-10s pc=0x%08h taken=%0b carry=%0b halted=%0b link_we=%0b",
                         ex.name, pc, taken, carry_q, halted, m_lwe);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        //   name         rst en st op     fz fs fc bt     target        alu_res       halt  pc            tk cy h  lwe laddr
        txn("reset",      1, 0, 0, 4'h0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h0,        0, 0, 0, 0, 32'h0);
        txn("seq1",       0, 1, 0, 4'h0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h4,        0, 0, 0, 0, 32'h0);
        txn("seq2",       0, 1, 0, 4'h0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h8,        0, 0, 0, 0, 32'h0);
        txn("seq3",       0, 1, 0, 4'h0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'hC,        0, 0, 0, 0, 32'h0);
        txn("b_to8",      0, 1, 0, 4'h0, 0, 0, 0, 4'd1,  32'h8,        32'h0,        0,    32'h8,        1, 0, 0, 0, 32'h0);
        txn("bz_take",    0, 1, 0, 4'h0, 1, 0, 0, 4'd5,  32'h40,       32'h0,        0,    32'h40,       1, 0, 0, 0, 32'h0);
        txn("b_back8",    0, 1, 0, 4'h0, 0, 0, 0, 4'd1,  32'h8,        32'h0,        0,    32'h8,        1, 0, 0, 0, 32'h0);
        txn("bz_fall",    0, 1, 0, 4'h0, 0, 0, 0, 4'd5,  32'h40,       32'h0,        0,    32'hC,        0, 0, 0, 0, 32'h0);
        txn("add_cy",     0, 1, 0, 4'h1, 0, 0, 1, 4'd0,  32'h0,        32'h0,        0,    32'h10,       0, 1, 0, 0, 32'h0);
        txn("bcy_take",   0, 1, 0, 4'h0, 0, 0, 0, 4'd7,  32'h100,      32'h0,        0,    32'h100,      1, 1, 0, 0, 32'h0);
        txn("comp_clr",   0, 1, 0, 4'h5, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h104,      0, 0, 0, 0, 32'h0);
        txn("bcy_nofwd",  0, 1, 0, 4'h1, 0, 0, 1, 4'd7,  32'h200,      32'h0,        0,    32'h108,      0, 1, 0, 0, 32'h0);
        txn("bncy_fall",  0, 1, 0, 4'h0, 0, 0, 0, 4'd8,  32'h300,      32'h0,        0,    32'h10C,      0, 1, 0, 0, 32'h0);
        txn("bltz_take",  0, 1, 0, 4'h0, 0, 1, 0, 4'd4,  32'h20,       32'h0,        0,    32'h20,       1, 1, 0, 0, 32'h0);
        txn("bl",         0, 1, 0, 4'h0, 0, 0, 0, 4'd2,  32'h80,       32'h0,        0,    32'h80,       1, 1, 0, 1, 32'h24);
        txn("br",         0, 1, 0, 4'h0, 0, 0, 0, 4'd3,  32'h0,        32'h24,       0,    32'h24,       1, 1, 0, 0, 32'h0);
        txn("op_nocy",    0, 1, 0, 4'h2, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h28,       0, 1, 0, 0, 32'h0);
        txn("stall",      0, 1, 1, 4'h1, 1, 0, 0, 4'd5,  32'h40,       32'h0,        0,    32'h28,       0, 1, 0, 0, 32'h0);
        txn("en_low_bl",  0, 0, 0, 4'h0, 0, 0, 0, 4'd2,  32'h80,       32'h0,        0,    32'h28,       0, 1, 0, 0, 32'h0);
        txn("bnz_take",   0, 1, 0, 4'h0, 0, 0, 0, 4'd6,  32'h50,       32'h0,        0,    32'h50,       1, 1, 0, 0, 32'h0);
        txn("b_top",      0, 1, 0, 4'h0, 0, 0, 0, 4'd1,  32'hFFFFFFFC, 32'h0,        0,    32'hFFFFFFFC, 1, 1, 0, 0, 32'h0);
        txn("wrap",       0, 1, 0, 4'h0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h0,        0, 1, 0, 0, 32'h0);
        txn("bt_undef",   0, 1, 0, 4'h0, 1, 1, 0, 4'd12, 32'h500,      32'h0,        0,    32'h4,        0, 1, 0, 0, 32'h0);
        txn("halt_br",    0, 1, 0, 4'h0, 0, 0, 0, 4'd3,  32'h0,        32'h99,       1,    32'h4,        0, 1, 1, 0, 32'h0);
        txn("halt_hold",  0, 1, 0, 4'h0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h4,        0, 1, 1, 0, 32'h0);
        txn("halt_bl",    0, 1, 0, 4'h0, 0, 0, 0, 4'd2,  32'h80,       32'h0,        0,    32'h4,        0, 1, 1, 0, 32'h0);
        txn("rst_halt",   1, 1, 0, 4'h0, 0, 0, 0, 4'd1,  32'h80,       32'h0,        1,    32'h0,        0, 0, 0, 0, 32'h0);
        txn("run_again",  0, 1, 0, 4'h0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,    32'h4,        0, 0, 0, 0, 32'h0);

        @(negedge clk);
        en = 1'b0; rst = 1'b0; halt_req = 1'b0; br_type = 4'd0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain got=%0d pending expected=0 pending", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
